// File: rtl/i2s_tx_buf_pkg.sv
// Shared constants and helpers for the I2S transmit sample buffer.
package i2s_tx_buf_pkg;

  localparam int unsigned I2S_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    I2S_CHM_STEREO = 2'b00,
    I2S_CHM_MONO   = 2'b01,
    I2S_CHM_LEFT   = 2'b10,
    I2S_CHM_RSVD   = 2'b11
  } i2s_chm_e;

  localparam logic [1:0] I2S_DAT_8_BITS  = 2'b00;
  localparam logic [1:0] I2S_DAT_16_BITS = 2'b01;
  localparam logic [1:0] I2S_DAT_24_BITS = 2'b10;
  localparam logic [1:0] I2S_DAT_32_BITS = 2'b11;

  // Left shift that moves a right-justified sample of the given length to the MSB.
  function automatic int unsigned align_shift(input logic [1:0] chl, input int unsigned width);
    int unsigned len;
    len = 8 * (int'(chl) + 1);
    return (len >= width) ? 0 : width - len;
  endfunction

endpackage

// File: rtl/i2s_tx_fifo.sv
// Generic synchronous FIFO with occupancy count; storage is not reset.
module i2s_tx_fifo #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned AW        = $clog2(DEPTH),
  localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clr_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [CW-1:0]         cnt_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wptr_q, wptr_d;
  logic [AW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  push_ok, pop_ok;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  assign push_ok = push_i && !full_o && !clr_i;
  assign pop_ok  = pop_i && !empty_o && !clr_i;

  // Pointer and count next state; clear overrides push and pop.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + AW'(1);
      if (pop_ok)  rptr_d = rptr_q + AW'(1);
      if (push_ok && !pop_ok)      cnt_d = cnt_q + CW'(1);
      else if (pop_ok && !push_ok) cnt_d = cnt_q - CW'(1);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Sample storage write port.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/i2s_tx_buf.sv
// I2S transmit buffer: FIFO plus channel-mode repeat, MSB alignment, IRQ and underrun.
module i2s_tx_buf
  import i2s_tx_buf_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = I2S_DATA_WIDTH,
  localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic                  flush_i,
  input  logic [1:0]            chm_i,
  input  logic [1:0]            chl_i,
  input  logic [CW-1:0]         thres_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic [CW-1:0]         cnt_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  thres_irq_o,
  output logic                  underrun_o
);

  logic [DATA_WIDTH-1:0] head;
  logic                  full, empty;
  logic [CW-1:0]         cnt;
  logic                  rep_q, rep_d;
  logic                  irq_q, irq_d;
  logic                  unr_q, unr_d;
  logic                  hs, pop, push, repeat_mode;
  i2s_chm_e              chm;

  assign chm         = i2s_chm_e'(chm_i);
  assign repeat_mode = (chm == I2S_CHM_MONO) || (chm == I2S_CHM_LEFT);

  assign wr_ready_o = ~full;
  assign push       = wr_valid_i && ~full;
  assign tx_valid_o = en_i && ~empty;
  assign hs         = tx_valid_o && tx_ready_i;

  i2s_tx_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_data_i),
    .rdata_o (head),
    .cnt_o   (cnt),
    .full_o  (full),
    .empty_o (empty)
  );

  assign cnt_o   = cnt;
  assign full_o  = full;
  assign empty_o = empty;

  // Repeat-slot tracking: mono/left keep the head for one extra handshake.
  always_comb begin
    rep_d = rep_q;
    pop   = 1'b0;
    if (flush_i) begin
      rep_d = 1'b0;
    end else if (hs) begin
      if (repeat_mode && !rep_q) begin
        rep_d = 1'b1;
      end else begin
        pop   = 1'b1;
        rep_d = 1'b0;
      end
    end
  end

  // Output word: MSB-aligned head, zero in the left-mode second slot or when idle.
  always_comb begin
    tx_data_o = '0;
    if (tx_valid_o && !((chm == I2S_CHM_LEFT) && rep_q)) begin
      tx_data_o = head << align_shift(chl_i, DATA_WIDTH);
    end
  end

  // Status conditions registered one cycle later.
  always_comb begin
    irq_d = en_i && (cnt <= thres_i);
    unr_d = en_i && tx_ready_i && empty;
  end

  // Repeat flag and status registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rep_q <= 1'b0;
      irq_q <= 1'b0;
      unr_q <= 1'b0;
    end else begin
      rep_q <= rep_d;
      irq_q <= irq_d;
      unr_q <= unr_d;
    end
  end

  assign thres_irq_o = irq_q;
  assign underrun_o  = unr_q;

endmodule

// File: doc/i2s_tx_buf.md
# i2s_tx_buf

Transmit sample buffer that sits directly upstream of the I2S transmitter core. Bus-side writes arrive as right-justified samples; the block stores them in a synchronous FIFO, applies channel-mode handling (stereo, mono duplication, left-only), and presents MSB-aligned words on a valid/ready interface to the transmitter. It also reports fill level, a threshold interrupt and underrun events to the register block.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of two, at least 4.
- DATA_WIDTH, `I2S_DATA_WIDTH (32): sample width.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- en_i  in  1  transmit enable; when low, pops are blocked.
- flush_i  in  1  one-cycle synchronous clear of the FIFO and the repeat state.
- chm_i  in  2  channel mode: `I2S_CHM_STEREO`, `I2S_CHM_MONO`, `I2S_CHM_LEFT`; the reserved code is treated as stereo.
- chl_i  in  2  sample length, using `I2S_DAT_8/16/24/32_BITS`.
- thres_i  in  $clog2(DEPTH+1)  low-water threshold.
- wr_valid_i  in  1  write request.
- wr_ready_o  out  1  write accept; equals ~full.
- wr_data_i  in  DATA_WIDTH  right-justified sample.
- tx_valid_o  out  1  word available to the transmitter.
- tx_ready_i  in  1  transmitter accepts the word.
- tx_data_o  out  DATA_WIDTH  MSB-aligned word.
- cnt_o  out  $clog2(DEPTH+1)  stored entries.
- empty_o, full_o  out  1  FIFO status.
- thres_irq_o  out  1  level signal: registered en_i && (cnt <= thres_i).
- underrun_o  out  1  one-cycle pulse.

## Operation
- Push: wr_valid_i && wr_ready_o writes wr_data_i at wptr. wptr and cnt each increment.
- Pop handshake (hs): tx_valid_o && tx_ready_i.
- tx_valid_o = en_i && ~empty.
- Stereo mode: every hs pops one entry.
- Mono mode: each entry is sent twice.
  - The first hs sets rep_q and keeps the head entry.
  - The second hs pops the entry and clears rep_q.
- Left mode: each entry occupies two slots.
  - The first hs sends the entry and sets rep_q, without popping.
  - The second hs sends zero data, then pops and clears rep_q.
- Alignment: tx_data_o = head << (DATA_WIDTH − 8·(chl_i+1)). Bits above the selected length in wr_data_i are discarded.
- tx_data_o is 0 whenever tx_valid_o is low.
- Changing chm_i mid-stream is allowed; rep_q is honoured only while chm_i is not stereo.
- Underrun: en_i && tx_ready_i && empty produces underrun_o = 1 on the next cycle.
- Boundary conditions:
  - Push and pop in the same cycle: cnt is unchanged and both pointers advance.
  - Push when full is impossible because wr_ready_o = 0. A same-cycle pop does not open a slot in that cycle.
  - Pop when empty is impossible because tx_valid_o = 0.
  - Pointers wrap modulo DEPTH. Full and empty are derived from cnt.
  - flush_i has priority over push and pop in the same cycle: pointers, cnt and rep_q go to 0. A concurrent write is dropped.
  - en_i low: writes are still accepted, and rep_q holds its value.

## Timing
- Reset values: wr_ready_o 1, tx_valid_o 0, tx_data_o 0, cnt_o 0, empty_o 1, full_o 0, thres_irq_o 0, underrun_o 0, rep_q 0.
- Write-to-valid latency: a push in cycle N gives tx_valid_o = 1 in cycle N+1 if en_i is high. There is no combinational path from wr_valid_i to tx_valid_o.
- Pop takes effect at the clock edge. The new head appears on tx_data_o in the following cycle.
- tx_ready_i is combinational only into the pointer, cnt and rep_q next-state logic. No output depends combinationally on tx_ready_i.
- thres_irq_o and underrun_o lag their conditions by one cycle.
- Reset asserted mid-operation clears all state immediately, without waiting for clk_i.

## Structure
- i2s_define.sv gains `I2S_CHM_STEREO` (2'b00), `I2S_CHM_MONO` (2'b01) and `I2S_CHM_LEFT` (2'b10). Existing `I2S_DAT_*` and `I2S_DATA_WIDTH` are reused.
- Storage and pointers live in one sub-module, i2s_tx_fifo: a generic sync FIFO with cnt, full and empty.
- The top level holds rep_q, the alignment shifter, the channel-mode logic, the IRQ and the underrun registers.
- Storage registers have no reset.

## Test plan
- Stereo, 16-bit, DEPTH 16: push 0x1234 and 0xABCD → tx_data_o 0x12340000 then 0xABCD0000; cnt returns to 0, empty_o = 1.
- Mono, 24-bit: push 0x00ABCDEF → two hs, each with 0xABCDEF00; cnt decrements only after the second hs.
- Left, 8-bit: push 0xFF5A → 0x5A000000, then 0x00000000; entry popped on the second hs.
- Fill with 16 writes → full_o = 1, wr_ready_o = 0, 17th write ignored. Then drain 16 with thres_i = 4 → thres_irq_o rises the cycle after cnt reaches 4.
- en_i = 1, empty, tx_ready_i pulsed → underrun_o single-cycle pulse. en_i = 0 with the same stimulus → no pulse.
- cnt 5 and mono rep_q set, then flush_i together with wr_valid_i → cnt 0, rep_q 0, write dropped. The next push is the first sample out.
